slc3_mem_bridge: RTL and testbench
==================================

# slc3_mem_bridge

Memory and memory-mapped I/O bridge directly downstream of the SLC-3 control unit. It turns the controller's level-held `Mem_OE`/`Mem_WE` strobes, the MAR address and the MDR write data into these outputs:
- single-cycle BRAM accesses;
- switch reads at the I/O address;
- HEX-display register writes.

It returns read data with a fixed 2-cycle latency, which matches the controller's three-wait-state read sequence.

## Interface
Parameters:
- `RAM_AW`, 10: BRAM word-address width. Addresses alias modulo 2^RAM_AW.
- `IO_ADDR`, 16'hFFFF: I/O address. A read returns the switches; a write loads the HEX register.

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Mem_OE`  in  1  read/enable strobe from the controller; held for ≥3 cycles.
- `Mem_WE`  in  1  write strobe from the controller; held for ≥1 cycle. It has priority over `Mem_OE`.
- `ADDR`  in  16  MAR contents.
- `Data_from_CPU`  in  16  MDR contents (write data).
- `Data_to_CPU`  out  16  read data toward the MDR input mux.
- `Rd_valid`  out  1  one-cycle pulse in the cycle `Data_to_CPU` carries fresh read data.
- `SW`  in  16  board switches; asynchronous.
- `HEX_Data`  out  16  registered value driving the hex display.
- `bram_en`  out  1  BRAM port enable.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  RAM_AW  BRAM word address.
- `bram_din`  out  16  BRAM write data.
- `bram_dout`  in  16  BRAM read data. The BRAM has a synchronous read plus an output register: data is valid 2 cycles after the `bram_en` cycle.

## Operation
Switch synchronizer:
- `SW` passes through a 2-flop synchronizer.
- Reads use the synchronized value only.

Request decode:
- `Mem_WE`=1 → write request, regardless of `Mem_OE`.
- `Mem_OE`=1 with `Mem_WE`=0 → read request.
- `io_hit` = (`ADDR` == IO_ADDR).

FSM states: IDLE, RD1, RD2, HOLD, WR_HOLD.
- **IDLE**
  - On a read request: `bram_en`=1 combinationally, with `bram_addr`=`ADDR[RAM_AW-1:0]`. Latch `ADDR`, `io_hit` and the synchronized SW; go to RD1.
  - On a write request, non-I/O: `bram_en`=`bram_we`=1 for this cycle only, with `bram_din`=`Data_from_CPU`.
  - On a write request, I/O: `HEX_Data` ← `Data_from_CPU` at the clock edge; BRAM is not touched.
  - After either write: go to WR_HOLD.
- **RD1**
  - Wait; `bram_addr` is held at the latched address.
  - `Mem_OE`=0 → abort to IDLE; `Data_to_CPU` is unchanged.
- **RD2** (data cycle)
  - `Data_to_CPU` = `bram_dout` (or the latched SW if I/O), passed combinationally.
  - `Rd_valid`=1.
  - The value is captured into the hold register at the edge.
  - Go to HOLD. If `Mem_OE` is already 0, go to IDLE instead.
- **HOLD**
  - Stay until `Mem_OE`=0, then go to IDLE.
  - No new access is started; a fresh read needs OE to deassert for ≥1 cycle.
- **WR_HOLD**
  - Stay while `Mem_WE`=1. Repeated WE cycles produce no further writes.
  - On `Mem_WE`=0 go to IDLE. If OE=1 at that point, it is ignored until OE drops.

Output rules:
- Outside RD2, `Data_to_CPU` = hold register, which holds the last read data.
- `bram_en`=0 in every state and condition not listed above.

## Timing
Reset values (asynchronous `Reset_n`=0, effective immediately):
- State = IDLE.
- `Data_to_CPU`=0, hold register=0, `HEX_Data`=0.
- `Rd_valid`=`bram_en`=`bram_we`=0.
- Synchronizer flops=0.
- Reset mid-read drops the transaction; reset mid-write after the write edge keeps the BRAM contents.

Read latency:
- OE is first seen in cycle t. Data is valid combinationally in cycle t+2 and is stable until t+2's edge.
- The controller's third OE cycle (its final MDR load) therefore samples correct data.
- Within a read, `Data_to_CPU` changes at most once.

Write timing:
- Exactly one `bram_we` pulse per WE assertion, in the first WE cycle.
- `HEX_Data` updates at the end of the first WE cycle.

Switch path: a switch change is visible to reads after 2 clocks of synchronizer delay.

`ADDR` changes after cycle t have no effect on the read in flight.

## Test plan
- Preload BRAM[0x012]=16'hBEEF. `ADDR`=0x0012, OE high 3 cycles → `bram_en` 1 cycle at t; `Rd_valid` and `Data_to_CPU`=BEEF at t+2; BEEF held after OE drops.
- `ADDR`=0x0040, `Data_from_CPU`=1234, WE and OE both high 3 cycles → exactly one `bram_we` pulse at t. A following read of 0x0040 returns 1234.
- `SW`=0x00A5, wait 3 cycles, read `ADDR`=0xFFFF → `Data_to_CPU`=00A5 at t+2 with `bram_en` 0. A write of 0x5A5A to 0xFFFF → `HEX_Data`=5A5A after 1 cycle, no `bram_we`.
- OE high 1 cycle only → no `Rd_valid`; `Data_to_CPU` keeps its prior value; FSM back to IDLE.
- Pulse `Reset_n` low mid-RD1 after a prior read of BEEF → all outputs 0 immediately. The next 3-cycle read completes normally at t+2.
- `ADDR`=0x0412 with RAM_AW=10 → aliases to word 0x012 and returns BEEF.

Source files
------------

// File: rtl/slc3_mem_bridge.sv
// Memory / memory-mapped I/O bridge between the SLC-3 controller strobes and a
// two-cycle-latency BRAM, plus the switch input and HEX display register.
module slc3_mem_bridge #(
   parameter int          RAM_AW  = 10,
   parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       ADDR,
   input  logic [15:0]       Data_from_CPU,
   output logic [15:0]       Data_to_CPU,
   output logic              Rd_valid,
   input  logic [15:0]       SW,
   output logic [15:0]       HEX_Data,
   output logic              bram_en,
   output logic              bram_we,
   output logic [RAM_AW-1:0] bram_addr,
   output logic [15:0]       bram_din,
   input  logic [15:0]       bram_dout
);

   // state   | meaning
   // IDLE    | waiting for a request; reads/writes are launched from here
   // RD1     | BRAM pipeline stage 1, address held at latched value
   // RD2     | data cycle, Data_to_CPU driven live and captured
   // HOLD    | read done, waiting for OE to drop
   // WR_HOLD | write done, waiting for WE to drop
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD1     = 3'd1;
   localparam logic [2:0] RD2     = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] WR_HOLD = 3'd4;

   logic [2:0]        state, state_nxt;
   logic [15:0]       sw_meta, sw_sync, rd_sw, hold_q, hex_q;
   logic [RAM_AW-1:0] rd_addr;
   logic              rd_io;
   logic              wr_req, rd_req, io_hit, is_idle;

   assign wr_req  = Mem_WE;
   assign rd_req  = Mem_OE & ~Mem_WE;
   assign io_hit  = (ADDR == IO_ADDR);
   // Qualified by Reset_n so every output reads zero while reset is held.
   assign is_idle = (state == IDLE) & Reset_n;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wr_req)      state_nxt = WR_HOLD;
            else if (rd_req) state_nxt = RD1;
         end
         RD1:     state_nxt = Mem_OE ? RD2 : IDLE;
         RD2:     state_nxt = Mem_OE ? HOLD : IDLE;
         HOLD:    if (!Mem_OE) state_nxt = IDLE;
         // OE still high when WE drops must not launch a read: park in HOLD.
         WR_HOLD: if (!Mem_WE) state_nxt = Mem_OE ? HOLD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         sw_meta <= '0;
         sw_sync <= '0;
         rd_sw   <= '0;
         rd_addr <= '0;
         rd_io   <= 1'b0;
         hold_q  <= '0;
         hex_q   <= '0;
      end else begin
         state   <= state_nxt;
         sw_meta <= SW;
         sw_sync <= sw_meta;
         if (is_idle && rd_req) begin
            rd_addr <= ADDR[RAM_AW-1:0];
            rd_io   <= io_hit;
            rd_sw   <= sw_sync;
         end
         if (is_idle && wr_req && io_hit) hex_q <= Data_from_CPU;
         if (state == RD2) hold_q <= Data_to_CPU;
      end
   end

   assign bram_en     = is_idle & (wr_req | rd_req) & ~io_hit;
   assign bram_we     = is_idle & wr_req & ~io_hit;
   assign bram_addr   = is_idle ? ADDR[RAM_AW-1:0] : rd_addr;
   assign bram_din    = Reset_n ? Data_from_CPU : 16'h0000;
   assign Rd_valid    = (state == RD2);
   assign Data_to_CPU = (state == RD2) ? (rd_io ? rd_sw : bram_dout) : hold_q;
   assign HEX_Data    = hex_q;

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed bench for slc3_mem_bridge with a two-cycle-latency BRAM model.
module tb_slc3_mem_bridge;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Mem_OE = 1'b0;
   logic        Mem_WE = 1'b0;
   logic [15:0] ADDR = '0;
   logic [15:0] Data_from_CPU = '0;
   logic [15:0] Data_to_CPU;
   logic        Rd_valid;
   logic [15:0] SW = '0;
   logic [15:0] HEX_Data;
   logic        bram_en, bram_we;
   logic [9:0]  bram_addr;
   logic [15:0] bram_din;
   logic [15:0] bram_dout;

   int n_total = 0;
   int n_pass  = 0;

   slc3_mem_bridge #(.RAM_AW(10), .IO_ADDR(16'hFFFF)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU),
      .Rd_valid(Rd_valid), .SW(SW), .HEX_Data(HEX_Data), .bram_en(bram_en),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout)
   );

   always #5 Clk = ~Clk;

   // BRAM: synchronous read plus output register
   logic [15:0] mem [0:1023];
   logic [15:0] r1 = '0, r2 = '0;
   logic        preload = 1'b1;
   always @(posedge Clk) begin
      if (preload) mem[10'h012] <= 16'hBEEF;
      else if (bram_en && bram_we) mem[bram_addr] <= bram_din;
      if (bram_en) r1 <= mem[bram_addr];
      r2 <= r1;
   end
   assign bram_dout = r2;

   task automatic cyc;
      @(posedge Clk);
      #1;
   endtask

   // 3-cycle OE read; reports data seen with Rd_valid, pulse count, first-cycle bram_en/addr, held data
   task automatic do_read(input logic [15:0] a, output logic [15:0] got, output int rv,
                          output logic en0, output logic [9:0] addr0, output logic [15:0] held);
      got = 16'hXXXX;
      rv  = 0;
      cyc;
      ADDR = a; Mem_OE = 1'b1;
      #1;
      en0 = bram_en; addr0 = bram_addr;
      if (Rd_valid) begin rv++; got = Data_to_CPU; end
      for (int i = 0; i < 2; i++) begin
         cyc;
         #1;
         if (Rd_valid) begin rv++; got = Data_to_CPU; end
      end
      cyc;
      Mem_OE = 1'b0;
      #1;
      held = Data_to_CPU;
   endtask

   task automatic test_reset;
      n_total++; if (Data_to_CPU !== 16'h0) $display("FAIL reset_data got=%h exp=0000", Data_to_CPU); else n_pass++;
      n_total++; if (HEX_Data !== 16'h0) $display("FAIL reset_hex got=%h exp=0000", HEX_Data); else n_pass++;
      n_total++; if ({Rd_valid, bram_en, bram_we} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {Rd_valid, bram_en, bram_we}); else n_pass++;
      cyc; preload = 1'b0; Reset_n = 1'b1;
      cyc;
   endtask

   task automatic test_read_beef;
      cyc;
      ADDR = 16'h0012; Mem_OE = 1'b1;
      #1;
      n_total++; if (bram_en !== 1'b1 || bram_addr !== 10'h012) $display("FAIL rd_t_en got en=%b addr=%h exp en=1 addr=012", bram_en, bram_addr); else n_pass++;
      n_total++; if (Rd_valid !== 1'b0) $display("FAIL rd_t_valid got=%b exp=0", Rd_valid); else n_pass++;
      cyc; #1;
      n_total++; if (bram_en !== 1'b0 || Rd_valid !== 1'b0) $display("FAIL rd_t1 got en=%b valid=%b exp 0 0", bram_en, Rd_valid); else n_pass++;
      cyc; #1;
      n_total++; if (Rd_valid !== 1'b1 || Data_to_CPU !== 16'hBEEF) $display("FAIL rd_t2 got valid=%b data=%h exp 1 BEEF", Rd_valid, Data_to_CPU); else n_pass++;
      cyc; Mem_OE = 1'b0; #1;
      n_total++; if (Rd_valid !== 1'b0 || Data_to_CPU !== 16'hBEEF) $display("FAIL rd_hold got valid=%b data=%h exp 0 BEEF", Rd_valid, Data_to_CPU); else n_pass++;
      cyc; #1;
      n_total++; if (Data_to_CPU !== 16'hBEEF) $display("FAIL rd_idle_hold got=%h exp=BEEF", Data_to_CPU); else n_pass++;
   endtask

   task automatic test_write;
      int we_cnt;
      logic [15:0] got, held;
      int rv;
      logic en0;
      logic [9:0] a0;
      we_cnt = 0;
      cyc;
      ADDR = 16'h0040; Data_from_CPU = 16'h1234; Mem_WE = 1'b1; Mem_OE = 1'b1;
      #1;
      n_total++; if (bram_we !== 1'b1 || bram_en !== 1'b1 || bram_din !== 16'h1234) $display("FAIL wr_t got we=%b en=%b din=%h exp 1 1 1234", bram_we, bram_en, bram_din); else n_pass++;
      if (bram_we) we_cnt++;
      for (int i = 0; i < 2; i++) begin
         cyc; #1;
         if (bram_we) we_cnt++;
      end
      cyc; Mem_WE = 1'b0; Mem_OE = 1'b0; #1;
      if (bram_we) we_cnt++;
      n_total++; if (we_cnt !== 1) $display("FAIL wr_pulses got=%0d exp=1", we_cnt); else n_pass++;
      do_read(16'h0040, got, rv, en0, a0, held);
      n_total++; if (got !== 16'h1234 || rv !== 1) $display("FAIL wr_readback got=%h pulses=%0d exp 1234 1", got, rv); else n_pass++;
   endtask

   task automatic test_io;
      logic [15:0] got, held;
      int rv;
      logic en0;
      logic [9:0] a0;
      SW = 16'h00A5;
      repeat (3) cyc;
      do_read(16'hFFFF, got, rv, en0, a0, held);
      n_total++; if (got !== 16'h00A5 || rv !== 1) $display("FAIL io_read got=%h pulses=%0d exp 00A5 1", got, rv); else n_pass++;
      n_total++; if (en0 !== 1'b0) $display("FAIL io_read_en got=%b exp=0", en0); else n_pass++;
      n_total++; if (held !== 16'h00A5) $display("FAIL io_held got=%h exp=00A5", held); else n_pass++;
      cyc;
      ADDR = 16'hFFFF; Data_from_CPU = 16'h5A5A; Mem_WE = 1'b1;
      #1;
      n_total++; if (bram_we !== 1'b0 || bram_en !== 1'b0) $display("FAIL io_wr_bram got we=%b en=%b exp 0 0", bram_we, bram_en); else n_pass++;
      n_total++; if (HEX_Data !== 16'h0000) $display("FAIL io_wr_early got=%h exp=0000", HEX_Data); else n_pass++;
      cyc; Mem_WE = 1'b0; #1;
      n_total++; if (HEX_Data !== 16'h5A5A) $display("FAIL io_hex got=%h exp=5A5A", HEX_Data); else n_pass++;
      cyc;
   endtask

   task automatic test_abort;
      logic [15:0] got, held;
      int rv;
      logic en0;
      logic [9:0] a0;
      cyc;
      ADDR = 16'h0012; Mem_OE = 1'b1;
      cyc; Mem_OE = 1'b0; #1;
      n_total++; if (Rd_valid !== 1'b0 || Data_to_CPU !== 16'h00A5) $display("FAIL abort_rd1 got valid=%b data=%h exp 0 00A5", Rd_valid, Data_to_CPU); else n_pass++;
      cyc; #1;
      n_total++; if (Rd_valid !== 1'b0 || Data_to_CPU !== 16'h00A5) $display("FAIL abort_after got valid=%b data=%h exp 0 00A5", Rd_valid, Data_to_CPU); else n_pass++;
      do_read(16'h0012, got, rv, en0, a0, held);
      n_total++; if (got !== 16'hBEEF || rv !== 1 || en0 !== 1'b1) $display("FAIL abort_next got=%h pulses=%0d en=%b exp BEEF 1 1", got, rv, en0); else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [15:0] got, held;
      int rv;
      logic en0;
      logic [9:0] a0;
      cyc;
      ADDR = 16'h0012; Mem_OE = 1'b1;
      cyc;
      Reset_n = 1'b0;
      #1;
      n_total++; if (Data_to_CPU !== 16'h0 || HEX_Data !== 16'h0) $display("FAIL rst_mid_data got data=%h hex=%h exp 0000 0000", Data_to_CPU, HEX_Data); else n_pass++;
      n_total++; if ({Rd_valid, bram_en, bram_we} !== 3'b000) $display("FAIL rst_mid_ctrl got=%b exp=000", {Rd_valid, bram_en, bram_we}); else n_pass++;
      cyc; Mem_OE = 1'b0; Reset_n = 1'b1;
      cyc;
      do_read(16'h0012, got, rv, en0, a0, held);
      n_total++; if (got !== 16'hBEEF || rv !== 1) $display("FAIL rst_mid_next got=%h pulses=%0d exp BEEF 1", got, rv); else n_pass++;
   endtask

   task automatic test_alias;
      logic [15:0] got, held;
      int rv;
      logic en0;
      logic [9:0] a0;
      do_read(16'h0412, got, rv, en0, a0, held);
      n_total++; if (a0 !== 10'h012 || got !== 16'hBEEF) $display("FAIL alias got addr=%h data=%h exp 012 BEEF", a0, got); else n_pass++;
   endtask

   task automatic test_addr_hold;
      cyc;
      ADDR = 16'h0040; Mem_OE = 1'b1;
      cyc;
      ADDR = 16'h0012;
      #1;
      n_total++; if (bram_addr !== 10'h040 || bram_en !== 1'b0) $display("FAIL addr_hold got addr=%h en=%b exp 040 0", bram_addr, bram_en); else n_pass++;
      cyc; #1;
      n_total++; if (Data_to_CPU !== 16'h1234 || Rd_valid !== 1'b1) $display("FAIL addr_hold_data got=%h valid=%b exp 1234 1", Data_to_CPU, Rd_valid); else n_pass++;
      cyc; Mem_OE = 1'b0;
      cyc;
   endtask

   initial begin
      #2;
      test_reset;
      test_read_beef;
      test_write;
      test_io;
      test_abort;
      test_reset_mid;
      test_alias;
      test_addr_hold;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
